// File: rtl/core_ma_lsu_load_align.sv
// core_ma_lsu_load_align
// Load-return alignment unit for the memory-access stage. Keeps up to DEPTH
// outstanding loads in issue order, merges the one or two bus beats of a
// misaligned access, shifts and extends the result, and silently drops beats
// owed to loads that a pipeline flush has killed.
//
// Ports
//   clk                     core clock, rising edge
//   rest                    asynchronous active-low reset
//   req_valid / req_ready   load issue handshake (ready = room in the FIFO)
//   req_offset              byte offset of the load inside the bus word
//   req_op_type             B=0 H=1 W=2 D=3 BU=4 HU=5 WU=6 (D/WU only for XLEN=64)
//   avl_m0_read_data(_valid) one returned bus beat, in issue order
//   flush                   kill all pending loads
//   rsp_data / rsp_valid    aligned, extended result; valid is a one-cycle pulse
//   proto_err               sticky: a beat arrived that nobody was waiting for
module core_ma_lsu_load_align #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rest,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OFFW-1:0] req_offset,
    input  logic [2:0]      req_op_type,
    input  logic [XLEN-1:0] avl_m0_read_data,
    input  logic            avl_m0_read_data_valid,
    input  logic            flush,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_valid,
    output logic            proto_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(2 * DEPTH) + 1;
    localparam int SW = OFFW + 2;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [DW-1:0] DROP_MAX = DW'(2 * DEPTH);
    localparam logic [SW-1:0] NB_C     = SW'(XLEN / 8);

    localparam logic [2:0] MEM_OP_B  = 3'd0;
    localparam logic [2:0] MEM_OP_H  = 3'd1;
    localparam logic [2:0] MEM_OP_W  = 3'd2;
    localparam logic [2:0] MEM_OP_D  = 3'd3;
    localparam logic [2:0] MEM_OP_BU = 3'd4;
    localparam logic [2:0] MEM_OP_HU = 3'd5;
    localparam logic [2:0] MEM_OP_WU = 3'd6;

    // Access size in bytes; illegal ops are treated as one-beat byte loads.
    function automatic logic [3:0] op_len(input logic [2:0] op);
        case (op)
            MEM_OP_B, MEM_OP_BU: op_len = 4'd1;
            MEM_OP_H, MEM_OP_HU: op_len = 4'd2;
            MEM_OP_W, MEM_OP_WU: op_len = 4'd4;
            MEM_OP_D:            op_len = 4'd8;
            default:             op_len = 4'd1;
        endcase
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        case (op)
            MEM_OP_B, MEM_OP_H, MEM_OP_W: op_signed = 1'b1;
            default:                      op_signed = 1'b0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            MEM_OP_B, MEM_OP_H, MEM_OP_W, MEM_OP_BU, MEM_OP_HU: op_legal = 1'b1;
            MEM_OP_D, MEM_OP_WU: op_legal = (XLEN == 64) ? 1'b1 : 1'b0;
            default:             op_legal = 1'b0;
        endcase
    endfunction

    // Keep the low nbytes bytes, fill the rest with the sign bit or zero.
    // A full-width access (W on XLEN=32, D on XLEN=64) passes through.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] a,
                                               input logic [3:0] nbytes,
                                               input logic sgn);
        int   top_i;
        logic top;
        top_i = 8 * int'(nbytes) - 1;
        if (top_i > XLEN - 1) top_i = XLEN - 1;
        top = sgn & a[top_i];
        for (int i = 0; i < XLEN; i++) extend[i] = (i <= top_i) ? a[i] : top;
    endfunction

    logic [OFFW-1:0] r_off [DEPTH];
    logic [2:0]      r_op  [DEPTH];
    logic [DEPTH-1:0] r_split;
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_phase;
    logic [XLEN-1:0] r_beat_buf;
    logic [DW-1:0]   r_drop_cnt;
    logic [XLEN-1:0] r_rsp_data;
    logic            r_rsp_valid;
    logic            r_proto_err;

    logic            w_enq, w_req_split, w_drop, w_take, w_store, w_done, w_unexp;
    logic [SW-1:0]   w_req_end;
    logic [OFFW-1:0] w_h_off;
    logic [2:0]      w_h_op;
    logic [XLEN-1:0] w_first, w_second, w_aligned, w_result;
    logic [DW-1:0]   w_owed, w_drop_base, w_drop_flush;
    logic [DW:0]     w_drop_sum;
    logic [PW-1:0]   w_idx;

    assign req_ready = (r_count < DEPTH_C);
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;
    assign proto_err = r_proto_err;

    // Request decode and head-of-queue beat classification.
    always_comb begin
        w_enq       = req_valid & req_ready & ~flush;
        w_req_end   = SW'(req_offset) + SW'(op_len(req_op_type));
        w_req_split = (w_req_end > NB_C);
        w_h_off     = r_off[r_rptr];
        w_h_op      = r_op[r_rptr];
        w_drop      = avl_m0_read_data_valid & (r_drop_cnt != {DW{1'b0}});
        w_take      = avl_m0_read_data_valid & ~w_drop & (r_count != {CW{1'b0}});
        w_unexp     = avl_m0_read_data_valid & ~w_drop & (r_count == {CW{1'b0}});
        w_store     = w_take & r_split[r_rptr] & ~r_phase;
        w_done      = w_take & ~w_store;
    end

    // Merge the buffered first beat with the current one, shift and extend.
    always_comb begin
        if (r_phase) begin
            w_first  = r_beat_buf;
            w_second = avl_m0_read_data;
        end else begin
            w_first  = avl_m0_read_data;
            w_second = {XLEN{1'b0}};
        end
        w_aligned = XLEN'({w_second, w_first} >> {w_h_off, 3'b000});
        if (op_legal(w_h_op)) begin
            w_result = extend(w_aligned, op_len(w_h_op), op_signed(w_h_op));
        end else begin
            w_result = {XLEN{1'b0}};
        end
    end

    // Beats still owed at a flush, counting a same-cycle beat as already received.
    always_comb begin
        w_owed = {DW{1'b0}};
        w_idx  = r_rptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + PW'(i);
            if (CW'(i) < r_count) begin
                w_owed = w_owed + DW'(1) + DW'(r_split[w_idx]);
            end else begin
                w_owed = w_owed;
            end
        end
        w_owed       = w_owed - DW'(r_phase) - DW'(w_take);
        w_drop_base  = r_drop_cnt - DW'(w_drop);
        w_drop_sum   = {1'b0, w_drop_base} + {1'b0, w_owed};
        if (w_drop_sum > {1'b0, DROP_MAX}) begin
            w_drop_flush = DROP_MAX;
        end else begin
            w_drop_flush = w_drop_sum[DW-1:0];
        end
    end

    // Queue control, drop accounting, error flag and response register.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_count     <= {CW{1'b0}};
            r_wptr      <= {PW{1'b0}};
            r_rptr      <= {PW{1'b0}};
            r_phase     <= 1'b0;
            r_drop_cnt  <= {DW{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= {XLEN{1'b0}};
            r_proto_err <= 1'b0;
        end else begin
            if (flush) begin
                r_count    <= {CW{1'b0}};
                r_wptr     <= {PW{1'b0}};
                r_rptr     <= {PW{1'b0}};
                r_phase    <= 1'b0;
                r_drop_cnt <= w_drop_flush;
            end else begin
                r_count    <= r_count + CW'(w_enq) - CW'(w_done);
                r_wptr     <= r_wptr + PW'(w_enq);
                r_rptr     <= r_rptr + PW'(w_done);
                r_drop_cnt <= w_drop_base;
                if (w_done) begin
                    r_phase <= 1'b0;
                end else if (w_store) begin
                    r_phase <= 1'b1;
                end
            end
            r_proto_err <= r_proto_err | w_unexp;
            r_rsp_valid <= w_done & ~flush;
            if (w_done & ~flush) r_rsp_data <= w_result;
        end
    end

    // Entry payload and first-beat buffer; contents are qualified by count/phase.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_off[r_wptr]   <= req_offset;
            r_op[r_wptr]    <= req_op_type;
            r_split[r_wptr] <= w_req_split;
        end
        if (w_store) r_beat_buf <= avl_m0_read_data;
    end
endmodule

// File: tb/tb_core_ma_lsu_load_align.sv
// Testbench for core_ma_lsu_load_align: one XLEN=32 and one XLEN=64 instance,
// each DEPTH=4, driven one at a time against a byte-level reference model.
module tb_core_ma_lsu_load_align;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rest = 1'b0, a_req_valid = 1'b0, a_req_ready, a_rdv = 1'b0, a_flush = 1'b0;
    logic [1:0]  a_off = 2'd0;
    logic [2:0]  a_op = 3'd0;
    logic [31:0] a_rd = 32'd0, a_rsp_data;
    logic        a_rsp_valid, a_perr;

    logic        b_rest = 1'b0, b_req_valid = 1'b0, b_req_ready, b_rdv = 1'b0, b_flush = 1'b0;
    logic [2:0]  b_off = 3'd0;
    logic [2:0]  b_op = 3'd0;
    logic [63:0] b_rd = 64'd0, b_rsp_data;
    logic        b_rsp_valid, b_perr;

    core_ma_lsu_load_align #(.XLEN(32), .DEPTH(4)) u32 (
        .clk(clk), .rest(a_rest), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_offset(a_off), .req_op_type(a_op), .avl_m0_read_data(a_rd),
        .avl_m0_read_data_valid(a_rdv), .flush(a_flush), .rsp_data(a_rsp_data),
        .rsp_valid(a_rsp_valid), .proto_err(a_perr));

    core_ma_lsu_load_align #(.XLEN(64), .DEPTH(4)) u64 (
        .clk(clk), .rest(b_rest), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_offset(b_off), .req_op_type(b_op), .avl_m0_read_data(b_rd),
        .avl_m0_read_data_valid(b_rdv), .flush(b_flush), .rsp_data(b_rsp_data),
        .rsp_valid(b_rsp_valid), .proto_err(b_perr));

    typedef struct { int off; int op; } ld_t;
    ld_t         q[$];
    int          xl = 32;
    bit          sel64 = 1'b0;
    bit          m_phase = 1'b0, m_perr = 1'b0;
    logic [63:0] m_buf = 64'd0;
    int          m_drop = 0;
    int          n_assert = 0, n_fail = 0;
    logic        o_ready, o_rv, o_perr;
    logic [63:0] o_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_len(input int op);
        case (op)
            0, 4:    return 1;
            1, 5:    return 2;
            2, 6:    return 4;
            3:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic bit m_legal(input int op);
        case (op)
            0, 1, 2, 4, 5: return 1'b1;
            3, 6:          return (xl == 64);
            default:       return 1'b0;
        endcase
    endfunction

    function automatic bit m_split(input int off, input int op);
        return (off + m_len(op)) > (xl / 8);
    endfunction

    // Lay both beats out as a byte string, pick len bytes from off, then extend.
    function automatic logic [63:0] m_result(input int off, input int op,
                                             input logic [63:0] first, input logic [63:0] second);
        logic [7:0]  by [16];
        logic [63:0] v;
        int nb, len;
        nb = xl / 8;
        for (int i = 0; i < nb; i++) begin
            by[i]      = first[8*i +: 8];
            by[nb + i] = second[8*i +: 8];
        end
        if (!m_legal(op)) return 64'd0;
        len = m_len(op);
        v = 64'd0;
        for (int i = 0; i < len; i++) v[8*i +: 8] = by[off + i];
        if ((op == 0 || op == 1 || op == 2) && v[8*len - 1])
            for (int b = 8 * len; b < xl; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic sample();
        if (sel64) begin
            o_ready = b_req_ready; o_rv = b_rsp_valid; o_data = b_rsp_data; o_perr = b_perr;
        end else begin
            o_ready = a_req_ready; o_rv = a_rsp_valid; o_data = {32'h0, a_rsp_data}; o_perr = a_perr;
        end
    endtask

    task automatic drive(input bit rv, input int off, input int op, input bit bv,
                         input logic [63:0] bd, input bit fl);
        a_req_valid = 1'b0; a_rdv = 1'b0; a_flush = 1'b0;
        b_req_valid = 1'b0; b_rdv = 1'b0; b_flush = 1'b0;
        if (sel64) begin
            b_req_valid = rv; b_off = 3'(off); b_op = 3'(op); b_rdv = bv; b_rd = bd; b_flush = fl;
        end else begin
            a_req_valid = rv; a_off = 2'(off); a_op = 3'(op); a_rdv = bv; a_rd = bd[31:0]; a_flush = fl;
        end
    endtask

    // One clock of stimulus: check req_ready, advance the model, check outputs.
    task automatic cyc(input bit rv, input int off, input int op, input bit bv,
                       input logic [63:0] bd, input bit fl);
        bit er, erv;
        logic [63:0] ed;
        int owed;
        drive(rv, off, op, bv, bd, fl);
        #1; sample();
        er = (q.size() < 4);
        chk("req_ready", 64'(o_ready), 64'(er));
        erv = 1'b0; ed = 64'd0;
        if (bv) begin
            if (m_drop > 0) m_drop--;
            else if (q.size() == 0) m_perr = 1'b1;
            else if (m_split(q[0].off, q[0].op) && !m_phase) begin
                m_buf = bd; m_phase = 1'b1;
            end else begin
                if (m_phase) ed = m_result(q[0].off, q[0].op, m_buf, bd);
                else         ed = m_result(q[0].off, q[0].op, bd, 64'd0);
                q.delete(0); m_phase = 1'b0; erv = !fl;
            end
        end
        if (fl) begin
            owed = 0;
            foreach (q[i]) owed += 1 + int'(m_split(q[i].off, q[i].op));
            owed -= int'(m_phase);
            m_drop = (m_drop + owed > 8) ? 8 : m_drop + owed;
            q.delete(); m_phase = 1'b0;
        end else if (rv && er) begin
            q.push_back('{off, op});
        end
        @(posedge clk); #1; sample();
        chk("rsp_valid", 64'(o_rv), 64'(erv));
        if (erv) chk("rsp_data", o_data, ed);
        chk("proto_err", 64'(o_perr), 64'(m_perr));
    endtask

    task automatic beat(input logic [63:0] d);
        cyc(1'b0, 0, 0, 1'b1, d, 1'b0);
    endtask

    task automatic do_reset(input bit s64);
        sel64 = s64; xl = s64 ? 64 : 32;
        drive(1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
        a_rest = 1'b0; b_rest = 1'b0;
        @(posedge clk); #1; sample();
        chk("rst_rsp_valid", 64'(o_rv), 64'd0);
        chk("rst_rsp_data", o_data, 64'd0);
        chk("rst_proto_err", 64'(o_perr), 64'd0);
        chk("rst_req_ready", 64'(o_ready), 64'd1);
        a_rest = 1'b1; b_rest = 1'b1;
        q.delete(); m_phase = 1'b0; m_perr = 1'b0; m_drop = 0;
    endtask

    function automatic int rand_op();
        int op;
        op = int'($urandom_range(0, 7));
        if (xl == 32 && (op == 3 || op == 6)) op = 2;
        return op;
    endfunction

    function automatic logic [63:0] rand_data();
        return {$urandom, $urandom};
    endfunction

    task automatic drain();
        int guard;
        guard = 0;
        while ((q.size() > 0 || m_drop > 0) && guard < 64) begin
            beat(rand_data()); guard++;
        end
        if (q.size() > 0 || m_drop > 0) begin
            n_assert++; n_fail++;
            $error("FAIL drain_timeout: observed %0d pending required 0", q.size());
        end
    endtask

    task automatic rand_run(input int n);
        bit bv;
        for (int k = 0; k < n; k++) begin
            bv = (q.size() > 0 || m_drop > 0) && ($urandom_range(0, 2) != 0);
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, xl / 8 - 1)), rand_op(),
                bv, rand_data(), ($urandom_range(0, 39) == 0));
        end
    endtask

    initial begin
        // ---------------- XLEN = 32 ----------------
        do_reset(1'b0);
        cyc(1'b1, 0, 2, 1'b0, 64'd0, 1'b0);
        beat(64'h8899AABB);
        chk("lw_aligned_valid", 64'(o_rv), 64'd1);
        chk("lw_aligned_data", o_data, 64'h8899AABB);
        cyc(1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
        chk("lw_single_pulse", 64'(o_rv), 64'd0);

        cyc(1'b1, 3, 0, 1'b0, 64'd0, 1'b0); beat(64'h80112233);
        chk("lb_sext", o_data, 64'hFFFFFF80);
        cyc(1'b1, 3, 4, 1'b0, 64'd0, 1'b0); beat(64'h80112233);
        chk("lbu_zext", o_data, 64'h00000080);
        cyc(1'b1, 2, 5, 1'b0, 64'd0, 1'b0); beat(64'hF0F01234);
        chk("lhu_zext", o_data, 64'h0000F0F0);

        cyc(1'b1, 3, 2, 1'b0, 64'd0, 1'b0);
        beat(64'h44332211);
        chk("split_no_early_valid", 64'(o_rv), 64'd0);
        beat(64'h88776655);
        chk("split_valid", 64'(o_rv), 64'd1);
        chk("split_data", o_data, 64'h77665544);

        for (int i = 0; i < 4; i++) cyc(1'b1, i, 4, 1'b0, 64'd0, 1'b0);
        chk("fifo_full_ready", 64'(o_ready), 64'd0);
        cyc(1'b1, 1, 0, 1'b1, 64'hA1B2C3D4, 1'b0);
        chk("ready_after_pop", 64'(o_ready), 64'd1);
        drain();

        for (int i = 0; i < 12; i++)
            cyc(1'b1, int'($urandom_range(0, 3)), rand_op(), (q.size() >= 2), rand_data(), 1'b0);
        drain();

        rand_run(400);
        drain();

        cyc(1'b1, 3, 2, 1'b0, 64'd0, 1'b0);
        beat(64'h11111111);
        do_reset(1'b0);
        cyc(1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
        chk("reset_midsplit_no_rsp", 64'(o_rv), 64'd0);
        cyc(1'b1, 0, 2, 1'b0, 64'd0, 1'b0); beat(64'h12345678);
        chk("post_reset_lw", o_data, 64'h12345678);

        cyc(1'b1, 3, 2, 1'b0, 64'd0, 1'b0);
        cyc(1'b1, 0, 0, 1'b0, 64'd0, 1'b0);
        beat(64'h44332211);
        cyc(1'b0, 0, 0, 1'b0, 64'd0, 1'b1);
        beat(64'h55555555);
        chk("flush_drop1", 64'(o_rv), 64'd0);
        beat(64'h66666666);
        chk("flush_drop2", 64'(o_rv), 64'd0);
        cyc(1'b1, 0, 2, 1'b0, 64'd0, 1'b0); beat(64'hCAFEF00D);
        chk("after_flush_lw", o_data, 64'hCAFEF00D);
        chk("after_flush_perr", 64'(o_perr), 64'd0);
        beat(64'hDEADBEEF);
        chk("unexpected_perr", 64'(o_perr), 64'd1);

        // ---------------- XLEN = 64 ----------------
        do_reset(1'b1);
        cyc(1'b1, 5, 3, 1'b0, 64'd0, 1'b0);
        beat(64'h0706050403020100);
        beat(64'h0F0E0D0C0B0A0908);
        chk("ld_split", o_data, 64'h0C0B0A0908070605);
        cyc(1'b1, 4, 2, 1'b0, 64'd0, 1'b0); beat(64'h80000000_00000000);
        chk("lw64_sext", o_data, 64'hFFFFFFFF_80000000);
        cyc(1'b1, 4, 6, 1'b0, 64'd0, 1'b0); beat(64'h80000000_00000000);
        chk("lwu64_zext", o_data, 64'h00000000_80000000);
        rand_run(300);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
